// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button input front end.
package button_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;

    localparam int unsigned BTN_U = 0;
    localparam int unsigned BTN_S = 1;
    localparam int unsigned BTN_D = 2;

    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// Debounce FSM for one synchronised button; registered level and press/release pulses.
// Optional auto-repeat of the press pulse while held, enabled by AUTO_REPEAT_EN.
module btn_debounce_fsm
    import button_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 8,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_PERIOD  = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic sample_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SAMPLES);

    btn_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [REP_W-1:0] rep_q;
    logic             rep_fire;
    logic             rep_wrap;

    // rep_q counts HELD ticks; after the first repeat it cycles REPEAT_DELAY..+REPEAT_PERIOD
    assign rep_wrap = (rep_q + REP_ONE) == REP_NEXT;
    assign rep_fire = ((rep_q + REP_ONE) == REP_FIRST) || rep_wrap;
`else
    // Repeat timing has no effect without auto-repeat.
    if (REPEAT_DELAY + REPEAT_PERIOD == 0) begin : g_no_repeat
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (tick_i) begin
                unique case (state_q)
                    IDLE: begin
                        if (sample_i) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sample_i) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q + CNT_ONE == CNT_MAX) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!sample_i) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= CNT_ONE;
                        end
`ifdef AUTO_REPEAT_EN
                        else begin
                            rep_q   <= rep_wrap ? REP_FIRST : rep_q + REP_ONE;
                            press_q <= rep_fire;
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        // A bounce back to 1 keeps the press alive; the repeat count is kept too.
                        if (sample_i) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else if (cnt_q + CNT_ONE == CNT_MAX) begin
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
`ifdef AUTO_REPEAT_EN
                            rep_q     <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Raw push-buttons -> 2-flop sync -> shared sample tick -> per-button debounce FSM.
// Define AUTO_REPEAT_EN to enable press auto-repeat while a button is held.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned N_BTN          = 3,
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned SAMPLE_HZ      = 1_000,
    parameter int unsigned STABLE_SAMPLES = 8,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_PERIOD  = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int unsigned TICK_DIV = tick_div(CLK_HZ, SAMPLE_HZ);
    localparam int unsigned TICK_W   = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    logic [N_BTN-1:0]  sync1_q;
    logic [N_BTN-1:0]  sync2_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TICK_ONE;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce_fsm #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_fsm (
            .clk_i     (clk),
            .rst_i     (rst),
            .tick_i    (tick),
            .sample_i  (sync2_q[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulses (kind, bit, cycle window) are queued
// when stimulus is driven and popped by a monitor as the DUT pulses.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int N          = 3;
    localparam int REP_DELAY  = 8;
    localparam int REP_PERIOD = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    typedef struct {
        bit rel;
        int idx;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   press_cnt[N]  = '{default: 0};
    int   last_press[N] = '{default: 0};

    button_conditioner #(
        .N_BTN          (N),
        .CLK_HZ         (1000),
        .SAMPLE_HZ      (100),
        .STABLE_SAMPLES (4),
        .REPEAT_DELAY   (REP_DELAY),
        .REPEAT_PERIOD  (REP_PERIOD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observed pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic hit;
        if (rst === 1'b0) begin
            checks++;
            if ((btn_press & btn_release) !== '0) begin
                errors++;
                $display("FAIL overlap: got press=%b release=%b, required no common bit",
                         btn_press, btn_release);
            end
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < N; i++) begin
                    hit = (k == 0) ? btn_press[i] : btn_release[i];
                    if (hit === 1'b1) begin
                        if (k == 0) begin
                            press_cnt[i]++;
                            last_press[i] = cyc;
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL scoreboard: got %s on bit %0d at cycle %0d, required none",
                                     (k == 0) ? "press" : "release", i, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.rel != (k == 1) || e.idx != i || cyc < e.lo || cyc > e.hi) begin
                                errors++;
                                $display("FAIL scoreboard: got %s bit %0d cycle %0d, required %s bit %0d cycles %0d..%0d",
                                         (k == 0) ? "press" : "release", i, cyc,
                                         e.rel ? "release" : "press", e.idx, e.lo, e.hi);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            wait_clks(1);
            n++;
        end
    endtask

    task automatic test_reset();
        int c0;
        int c1;
        rst     = 1'b1;
        btn_raw = 3'b111;
        for (int i = 0; i < 20; i++) begin
            wait_clks(1);
            checks++;
            if ({btn_level, btn_press, btn_release} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got level=%b press=%b release=%b, required all 0",
                         btn_level, btn_press, btn_release);
            end
        end
        rst = 1'b0;
        c0  = cyc;
        // Tick at 10 clks after release, sync already settled: 4th tick is exactly 40 clks on.
        for (int i = 0; i < N; i++) exp_q.push_back('{rel: 1'b0, idx: i, lo: c0 + 40, hi: c0 + 40});
        wait_empty(60);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_first_press: got %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (btn_level !== 3'b111) begin
            errors++;
            $display("FAIL reset_level: got %b, required 111", btn_level);
        end
        btn_raw = '0;
        c1      = cyc;
        for (int i = 0; i < N; i++) exp_q.push_back('{rel: 1'b1, idx: i, lo: c1 + 33, hi: c1 + 53});
        wait_empty(70);
        checks++;
        if (exp_q.size() != 0 || btn_level !== '0) begin
            errors++;
            $display("FAIL reset_release: got %0d outstanding level=%b, required 0 and 000",
                     exp_q.size(), btn_level);
            exp_q.delete();
        end
    endtask

    task automatic test_clean_press();
        int c0;
        int c1;
        int base;
        base = press_cnt[BTN_S];
        btn_raw[BTN_S] = 1'b1;
        c0 = cyc;
        exp_q.push_back('{rel: 1'b0, idx: BTN_S, lo: c0 + 33, hi: c0 + 53});
        wait_clks(99);
        checks++;
        if (btn_level[BTN_S] !== 1'b1) begin
            errors++;
            $display("FAIL clean_level_held: got %b, required 1", btn_level[BTN_S]);
        end
        wait_clks(1);
        btn_raw[BTN_S] = 1'b0;
        c1 = cyc;
        exp_q.push_back('{rel: 1'b1, idx: BTN_S, lo: c1 + 33, hi: c1 + 53});
        wait_empty(70);
        checks++;
        if (exp_q.size() != 0 || btn_level[BTN_S] !== 1'b0) begin
            errors++;
            $display("FAIL clean_release: got %0d outstanding level=%b, required 0 and 0",
                     exp_q.size(), btn_level[BTN_S]);
            exp_q.delete();
        end
        checks++;
        if (press_cnt[BTN_S] - base != 1) begin
            errors++;
            $display("FAIL clean_press_count: got %0d, required 1", press_cnt[BTN_S] - base);
        end
    endtask

    task automatic test_bounce();
        int c0;
        int c1;
        int base;
        base = press_cnt[BTN_U];
        c0 = cyc;
        // Earliest run of four high samples starts on the 42..48 high window.
        exp_q.push_back('{rel: 1'b0, idx: BTN_U, lo: c0 + 75, hi: c0 + 113});
        for (int t = 0; t < 60; t++) begin
            btn_raw[BTN_U] = ((t / 7) % 2 == 0);
            wait_clks(1);
        end
        btn_raw[BTN_U] = 1'b1;
        while (cyc < c0 + 150) wait_clks(1);
        checks++;
        if (exp_q.size() != 0 || btn_level[BTN_U] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_accept: got %0d outstanding level=%b, required 0 and 1",
                     exp_q.size(), btn_level[BTN_U]);
            exp_q.delete();
        end
        btn_raw[BTN_U] = 1'b0;
        c1 = cyc;
        exp_q.push_back('{rel: 1'b1, idx: BTN_U, lo: c1 + 33, hi: c1 + 53});
        wait_empty(70);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_release: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (press_cnt[BTN_U] - base != 1) begin
            errors++;
            $display("FAIL bounce_press_count: got %0d, required 1", press_cnt[BTN_U] - base);
        end
    endtask

    task automatic test_glitch();
        int base;
        base = press_cnt[BTN_D];
        btn_raw[BTN_D] = 1'b1;
        for (int t = 0; t < 65; t++) begin
            if (t == 25) btn_raw[BTN_D] = 1'b0;
            wait_clks(1);
            checks++;
            if (btn_level[BTN_D] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_level: got %b at step %0d, required 0", btn_level[BTN_D], t);
            end
        end
        checks++;
        if (press_cnt[BTN_D] != base) begin
            errors++;
            $display("FAIL glitch_press_count: got %0d, required 0", press_cnt[BTN_D] - base);
        end
    endtask

    task automatic test_simultaneous();
        int c0;
        btn_raw = 3'b111;
        c0 = cyc;
        for (int i = 0; i < N; i++) exp_q.push_back('{rel: 1'b0, idx: i, lo: c0 + 33, hi: c0 + 53});
        wait_empty(60);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL simul_press: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (last_press[1] != last_press[0] || last_press[2] != last_press[0]) begin
            errors++;
            $display("FAIL simul_same_clk: got cycles %0d %0d %0d, required all equal",
                     last_press[0], last_press[1], last_press[2]);
        end
        wait_clks(5);
        checks++;
        if (btn_level !== 3'b111) begin
            errors++;
            $display("FAIL simul_level: got %b, required 111", btn_level);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release} !== '0) begin
            errors++;
            $display("FAIL reset_while_held: got level=%b press=%b release=%b, required all 0",
                     btn_level, btn_press, btn_release);
        end
        btn_raw = '0;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(60);
        checks++;
        if (btn_level !== '0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_idle: got level=%b outstanding=%0d, required 000 and 0",
                     btn_level, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_auto_repeat();
        int c0;
        int c1;
        int a;
        int base;
        int n_rep;
        int budget;
        n_rep = 0;
        base  = press_cnt[BTN_S];
        btn_raw[BTN_S] = 1'b1;
        c0 = cyc;
        exp_q.push_back('{rel: 1'b0, idx: BTN_S, lo: c0 + 33, hi: c0 + 53});
        budget = 0;
        while (press_cnt[BTN_S] == base && budget < 60) begin
            wait_clks(1);
            budget++;
        end
        checks++;
        if (press_cnt[BTN_S] == base) begin
            errors++;
            $display("FAIL repeat_accept: got no press within 60 clks, required one");
        end
        a = last_press[BTN_S];
`ifdef AUTO_REPEAT_EN
        // HELD tick m lands at a+10m; the last tick that still sees the pin high is c0+402.
        for (int m = REP_DELAY; a + 10 * m <= c0 + 402; m += REP_PERIOD) begin
            exp_q.push_back('{rel: 1'b0, idx: BTN_S, lo: a + 10 * m, hi: a + 10 * m});
            n_rep++;
        end
`endif
        while (cyc < c0 + 400) wait_clks(1);
        btn_raw[BTN_S] = 1'b0;
        c1 = cyc;
        exp_q.push_back('{rel: 1'b1, idx: BTN_S, lo: c1 + 33, hi: c1 + 53});
        wait_empty(70);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL repeat_release: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (press_cnt[BTN_S] - base != 1 + n_rep) begin
            errors++;
            $display("FAIL repeat_press_count: got %0d, required %0d",
                     press_cnt[BTN_S] - base, 1 + n_rep);
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_auto_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1);
    end

endmodule
